mult_arbiter: RTL

- Shares one `multiplier` instance between two requesters.
- Accepts an operand pair from whichever requester wins round-robin arbitration, then drives the multiplier's bus protocol: load M, load Q, start, wait for ready, read low half, read high half.
- Returns the 2n-bit product to the winner with a one-cycle done pulse.
- Sits between client logic and the multiplier's `start`/`func`/`oe`/`ready`/`data` pins.

---
 rtl/mult_ctrl_pkg.sv | 33 +++
 rtl/rr_arbiter2.sv | 23 ++
 rtl/mult_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mult_ctrl_pkg.sv
// Shared types and encodings for the multiplier-sharing controller.
package mult_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LDM,
    S_LDQ,
    S_START,
    S_ARM,
    S_RUN,
    S_RDLO,
    S_RDHI,
    S_DONE
  } state_t;

  localparam logic [1:0] FUNC_LDM  = 2'b00;
  localparam logic [1:0] FUNC_LDQ  = 2'b01;
  localparam logic [1:0] FUNC_RDLO = 2'b10;
  localparam logic [1:0] FUNC_RDHI = 2'b11;

  localparam int unsigned ARM_WAIT = 2;

  // func rests at RDLO so the multiplier never latches M/Q by accident
  function automatic logic [1:0] state_func(state_t s);
    case (s)
      S_LDM:   state_func = FUNC_LDM;
      S_LDQ:   state_func = FUNC_LDQ;
      S_RDHI:  state_func = FUNC_RDHI;
      default: state_func = FUNC_RDLO;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; pointer records which requester was served last.
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant_c
);

  logic last;

  always_comb begin
    grant_c = req;
    if (req == 2'b11) grant_c = last ? 2'b01 : 2'b10;
  end

  // reset to "1 served last" so requester 0 wins the first tie
  always_ff @(posedge clock or posedge reset) begin
    if (reset)             last <= 1'b1;
    else if (en && |req)   last <= grant_c[1];
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one multiplier between two requesters: arbitrate, load M/Q, start,
// wait for ready (with abort), read both halves, return product with done.
module mult_arbiter
  import mult_ctrl_pkg::*;
#(
  parameter int unsigned n         = 8,
  parameter int unsigned RUN_LIMIT = 2 * n + 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [1:0]     req,
  input  logic [n-1:0]   a0,
  input  logic [n-1:0]   b0,
  input  logic [n-1:0]   a1,
  input  logic [n-1:0]   b1,
  output logic [1:0]     gnt,
  output logic [1:0]     done,
  output logic [2*n-1:0] product,
  output logic           err,
  output logic           busy,
  output logic           start,
  output logic [1:0]     func,
  output logic           oe,
  input  logic           ready,
  inout  wire  [n-1:0]   data
);

  localparam int unsigned RW = $clog2(RUN_LIMIT + 1);
  localparam int unsigned AW = $clog2(ARM_WAIT + 1);

  state_t        state, state_nx;
  logic [RW-1:0] run_cnt, run_cnt_nx;
  logic [AW-1:0] arm_cnt, arm_cnt_nx;
  logic [n-1:0]  op_a, op_b, lo_q;
  logic          sel_q;
  logic [1:0]    grant_c;
  logic          abort_c;

  rr_arbiter2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .en      (state == S_IDLE),
    .grant_c (grant_c)
  );

  // grant is offered only while idle; operands are captured at the closing edge
  assign gnt = (state == S_IDLE && !reset) ? grant_c : 2'b00;

  assign data = (state == S_LDM) ? op_a :
                (state == S_LDQ) ? op_b : {n{1'bz}};

  assign abort_c = (state == S_RUN) && !ready && (run_cnt == RW'(RUN_LIMIT - 1));

  always_comb begin
    state_nx   = state;
    run_cnt_nx = run_cnt;
    arm_cnt_nx = arm_cnt;
    case (state)
      S_IDLE:  if (|req) state_nx = S_LDM;
      S_LDM:   state_nx = S_LDQ;
      S_LDQ:   state_nx = S_START;
      S_START: begin
        state_nx   = S_ARM;
        arm_cnt_nx = '0;
      end
      // ready still high after the settle window means a combinational multiplier
      S_ARM: begin
        if (!ready) begin
          state_nx   = S_RUN;
          run_cnt_nx = '0;
        end else if (arm_cnt == AW'(ARM_WAIT - 1)) begin
          state_nx = S_RDLO;
        end else begin
          arm_cnt_nx = arm_cnt + AW'(1);
        end
      end
      S_RUN: begin
        if (ready)        state_nx = S_RDLO;
        else if (abort_c) state_nx = S_DONE;
        else              run_cnt_nx = run_cnt + RW'(1);
      end
      S_RDLO:  state_nx = S_RDHI;
      S_RDHI:  state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      run_cnt <= '0;
      arm_cnt <= '0;
      op_a    <= '0;
      op_b    <= '0;
      lo_q    <= '0;
      sel_q   <= 1'b0;
      done    <= 2'b00;
      err     <= 1'b0;
      product <= '0;
      busy    <= 1'b0;
      start   <= 1'b0;
      func    <= FUNC_RDLO;
      oe      <= 1'b0;
    end else begin
      state   <= state_nx;
      run_cnt <= run_cnt_nx;
      arm_cnt <= arm_cnt_nx;
      if (state == S_IDLE && |grant_c) begin
        op_a  <= grant_c[1] ? a1 : a0;
        op_b  <= grant_c[1] ? b1 : b0;
        sel_q <= grant_c[1];
      end
      if (state == S_RDLO) lo_q <= data;
      // product only changes on entry to DONE so it holds between done pulses
      if (state_nx == S_DONE) product <= abort_c ? '0 : {data, lo_q};
      done  <= (state_nx == S_DONE) ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
      err   <= abort_c;
      busy  <= (state_nx != S_IDLE);
      start <= (state_nx == S_START);
      func  <= state_func(state_nx);
      oe    <= (state_nx == S_RDLO) || (state_nx == S_RDHI);
    end
  end

endmodule
